screen_write_bridge: RTL and testbench

// - Snoops CPU data-memory writes (addressM/outM/writeM) and picks out those in the Screen region.
// - Queues them in a FIFO and replays them to the Vga VRAM write port with a valid/ready handshake.
// - Sits between Computer and Vga; replaces the ad-hoc VRAM write logic in the top level.
// - Parametrised region, depth and address width; optional 1bpp->colour pixel expansion.

---
 rtl/screen_write_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_screen_write_bridge.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_write_bridge.sv
// screen_write_bridge: snoops CPU data-memory writes that land in the Screen region,
// queues them in a small FIFO and replays them, in CPU order, on a valid/ready VRAM
// write port.
// Optional feature macro: SCREEN_BRIDGE_EXPAND_EN. When defined, each queued word is
// expanded into 16 pixel writes (bit k -> pixel offset*16+k, FG_COLOR/BG_COLOR).
module screen_write_bridge #(
  parameter int unsigned BASE_ADDR    = 16384,
  parameter int unsigned REGION_WORDS = 8192,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned VRAM_ADDR_W  = 17,
  parameter logic [15:0] FG_COLOR     = 16'h0000,
  parameter logic [15:0] BG_COLOR     = 16'h0FFF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [14:0]                 cpu_addr,
  input  logic [15:0]                 cpu_data,
  input  logic                        cpu_we,
  output logic [VRAM_ADDR_W-1:0]      vram_addr,
  output logic [15:0]                 vram_data,
  output logic                        vram_we,
  input  logic                        vram_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        clear_ovf,
  output logic                        busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef logic [VRAM_ADDR_W-1:0] vaddr_t;
  typedef logic [LvlW-1:0]        lvl_t;

  typedef struct packed {
    logic [14:0] off;
    logic [15:0] data;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StIssue, StExpand} state_e;

  // ---------------------------------------------------------------------------
  // Region decode
  // ---------------------------------------------------------------------------
  logic [31:0] addr_ext;
  logic        hit;
  logic [14:0] hit_off;

  assign addr_ext = {17'd0, cpu_addr};
  assign hit      = cpu_we && (addr_ext >= BASE_ADDR) && (addr_ext < BASE_ADDR + REGION_WORDS);
  assign hit_off  = cpu_addr - 15'(BASE_ADDR);

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  entry_t        mem_q [FIFO_DEPTH];
  logic [PtrW:0] wr_ptr_q, rd_ptr_q;
  lvl_t          level;
  logic          full, empty, push, pop;
  entry_t        head;

  // Pointers carry one extra bit so that full and empty differ.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == lvl_t'(FIFO_DEPTH));
  assign empty = (level == '0);
  // Full is judged on current occupancy, before any same-cycle pop frees a slot.
  assign push  = hit && !full;
  assign head  = mem_q[rd_ptr_q[PtrW-1:0]];

  // Storage array; occupancy lives in the pointers, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= '{off: hit_off, data: cpu_data};
    end
  end

  // Read/write pointers advance on push and pop independently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Sticky overflow: a dropped Screen write sets it, and setting beats clearing.
  logic overflow_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (hit && full) begin
      overflow_q <= 1'b1;
    end else if (clear_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FSM
  // ---------------------------------------------------------------------------
  state_e state_q;
  logic   we_q;
  vaddr_t addr_q;
  logic [15:0] data_q;

`ifdef SCREEN_BRIDGE_EXPAND_EN
  logic [14:0] off_q;
  logic [15:0] word_q;
  logic [3:0]  k_q;
  logic [3:0]  k_nxt;

  assign k_nxt = k_q + 4'd1;

  function automatic vaddr_t pix_addr(input logic [14:0] off, input logic [3:0] k);
    return vaddr_t'({off, k});
  endfunction

  function automatic logic [15:0] pix_color(input logic set);
    return set ? FG_COLOR : BG_COLOR;
  endfunction
`else
  logic [15:0] unused_colors;
  assign unused_colors = FG_COLOR ^ BG_COLOR;
`endif

  // Pop decision: from idle whenever data waits, otherwise only as the last
  // beat of the current item is accepted.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      StIdle:   pop = !empty;
`ifdef SCREEN_BRIDGE_EXPAND_EN
      StExpand: pop = !empty && vram_ready && (k_q == 4'hF);
`else
      StIssue:  pop = !empty && vram_ready;
`endif
      default:  pop = 1'b0;
    endcase
  end

  // State and registered VRAM outputs; outputs only change on acceptance or from idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef SCREEN_BRIDGE_EXPAND_EN
      off_q   <= '0;
      word_q  <= '0;
      k_q     <= '0;
`endif
    end else begin
      case (state_q)
`ifdef SCREEN_BRIDGE_EXPAND_EN
        StIdle: begin
          if (pop) begin
            off_q   <= head.off;
            word_q  <= head.data;
            k_q     <= 4'd0;
            addr_q  <= pix_addr(head.off, 4'd0);
            data_q  <= pix_color(head.data[0]);
            we_q    <= 1'b1;
            state_q <= StExpand;
          end
        end
        StExpand: begin
          if (vram_ready) begin
            if (k_q != 4'hF) begin
              k_q    <= k_nxt;
              addr_q <= pix_addr(off_q, k_nxt);
              data_q <= pix_color(word_q[k_nxt]);
            end else if (pop) begin
              off_q  <= head.off;
              word_q <= head.data;
              k_q    <= 4'd0;
              addr_q <= pix_addr(head.off, 4'd0);
              data_q <= pix_color(head.data[0]);
            end else begin
              we_q    <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
`else
        StIdle: begin
          if (pop) begin
            addr_q  <= vaddr_t'(head.off);
            data_q  <= head.data;
            we_q    <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (vram_ready) begin
            if (pop) begin
              addr_q <= vaddr_t'(head.off);
              data_q <= head.data;
            end else begin
              we_q    <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
`endif
        default: begin
          we_q    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign vram_we    = we_q;
  assign vram_addr  = addr_q;
  assign vram_data  = data_q;
  assign fifo_level = level;
  assign overflow   = overflow_q;
  assign busy       = (level != '0) | we_q;

endmodule

// File: tb/tb_screen_write_bridge.sv
// Self-checking bench for screen_write_bridge: vector table for region decode,
// hand-written sequences for latency, overflow, stalls and async reset, and a
// scoreboard queue checked against every accepted VRAM write.
`timescale 1ns/1ps
module tb_screen_write_bridge;

  localparam logic [15:0] Fg = 16'h0000;
  localparam logic [15:0] Bg = 16'h0FFF;
`ifdef SCREEN_BRIDGE_EXPAND_EN
  localparam int Beats = 16;
`else
  localparam int Beats = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_we;
  logic [16:0] vram_addr;
  logic [15:0] vram_data;
  logic        vram_we;
  logic        vram_ready;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        clear_ovf;
  logic        busy;

  screen_write_bridge dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_we     (cpu_we),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .vram_we    (vram_we),
    .vram_ready (vram_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
    logic        we;
    logic        hit;
  } vec_t;

  exp_t sb_q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   accepted = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference model: what the VRAM port must emit for one accepted CPU write.
  task automatic model_push(input logic [14:0] a, input logic [15:0] d);
    exp_t e;
    logic [16:0] off;
    off = {2'b00, a} - 17'd16384;
    for (int k = 0; k < Beats; k++) begin
      if (Beats == 1) begin
        e.addr = off;
        e.data = d;
      end else begin
        e.addr = 17'((off << 4) | 17'(k));
        e.data = d[k] ? Fg : Bg;
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [15:0] d, input logic we,
                           input logic exp_push);
    cpu_addr = a;
    cpu_data = d;
    cpu_we   = we;
    if (exp_push) model_push(a, d);
    step();
    cpu_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    chk({name, "_drain"}, 64'(busy), 64'd0);
    chk({name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: sampled mid-cycle, compares each accepted write and
  // checks that a stalled write is held unchanged.
  logic        stall_q = 1'b0;
  logic [16:0] held_addr;
  logic [15:0] held_data;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_stable", {vram_we, vram_addr, vram_data}, {1'b1, held_addr, held_data});
      end
      if (vram_we && vram_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, expected none",
                   vram_addr, vram_data);
        end else begin
          e = sb_q.pop_front();
          chk("vram_write", {vram_addr, vram_data}, {e.addr, e.data});
          accepted++;
        end
      end
      stall_q   = vram_we && !vram_ready;
      held_addr = vram_addr;
      held_data = vram_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    int   acc0;

    vecs[0] = '{addr: 15'h3FFF, data: 16'hAAAA, we: 1'b1, hit: 1'b0};
    vecs[1] = '{addr: 15'h6000, data: 16'h5555, we: 1'b1, hit: 1'b0};
    vecs[2] = '{addr: 15'h5FFF, data: 16'hBEEF, we: 1'b1, hit: 1'b1};
    vecs[3] = '{addr: 15'h4000, data: 16'h0000, we: 1'b1, hit: 1'b1};
    vecs[4] = '{addr: 15'h4ABC, data: 16'hFFFF, we: 1'b1, hit: 1'b1};
    vecs[5] = '{addr: 15'h4100, data: 16'h1111, we: 1'b0, hit: 1'b0};
    vecs[6] = '{addr: 15'h7FFF, data: 16'h2222, we: 1'b1, hit: 1'b0};
    vecs[7] = '{addr: 15'h0000, data: 16'h3333, we: 1'b1, hit: 1'b0};

    reset_n    = 1'b0;
    cpu_addr   = '0;
    cpu_data   = '0;
    cpu_we     = 1'b0;
    vram_ready = 1'b0;
    clear_ovf  = 1'b0;
    #1;
    chk("reset_we", 64'(vram_we), 64'd0);
    chk("reset_addr_data", {vram_addr, vram_data}, 64'd0);
    chk("reset_level", 64'(fifo_level), 64'd0);
    chk("reset_ovf_busy", {overflow, busy}, 64'd0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Single write: latency and one-cycle pulse.
    vram_ready = 1'b1;
    cpu_write(15'h4000, 16'h1234, 1'b1, 1'b1);
    chk("t2_level_after_hit", 64'(fifo_level), 64'd1);
    chk("t2_we_not_yet", 64'(vram_we), 64'd0);
    step();
    chk("t2_we", 64'(vram_we), 64'd1);
    chk("t2_addr", 64'(vram_addr), 64'd0);
`ifdef SCREEN_BRIDGE_EXPAND_EN
    chk("t2_data_pix0", 64'(vram_data), 64'(Bg));
`else
    chk("t2_data", 64'(vram_data), 64'h1234);
    step();
    chk("t2_we_one_cycle", 64'(vram_we), 64'd0);
`endif
    wait_idle("t2");

    // Region decode table.
    for (int i = 0; i < 8; i++) begin
      cpu_write(vecs[i].addr, vecs[i].data, vecs[i].we, vecs[i].hit);
      chk($sformatf("vec%0d_level", i), 64'(fifo_level), vecs[i].hit ? 64'd1 : 64'd0);
      wait_idle($sformatf("vec%0d", i));
    end

    // Push and pop in the same cycle leave the level unchanged.
    cpu_write(15'h4010, 16'h00A1, 1'b1, 1'b1);
    cpu_write(15'h4011, 16'h00B2, 1'b1, 1'b1);
    chk("pushpop_level", 64'(fifo_level), 64'd1);
    chk("pushpop_we", 64'(vram_we), 64'd1);
    wait_idle("pushpop");

    // Fill under stall, overflow, set-beats-clear, clear.
    vram_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      cpu_write(15'(32'h4200 + i), 16'(32'hC000 + i), 1'b1, 1'b1);
    end
    chk("full_level", 64'(fifo_level), 64'd16);
    chk("full_no_ovf", 64'(overflow), 64'd0);
    chk("full_we", 64'(vram_we), 64'd1);
    cpu_write(15'h4300, 16'hDEAD, 1'b1, 1'b0);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_level", 64'(fifo_level), 64'd16);
    clear_ovf = 1'b1;
    cpu_write(15'h4301, 16'hBEEF, 1'b1, 1'b0);
    clear_ovf = 1'b0;
    chk("ovf_set_wins", 64'(overflow), 64'd1);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'd0);
    acc0       = accepted;
    vram_ready = 1'b1;
    wait_idle("drain17");
    chk("drain17_count", 64'(accepted - acc0), 64'(17 * Beats));

    // Ready toggling every cycle.
    acc0 = accepted;
    for (int i = 0; i < 40; i++) begin
      vram_ready = i[0];
      if (i < 4) begin
        cpu_addr = 15'(32'h4400 + i * 3);
        cpu_data = 16'(32'h9A00 + i * 17);
        cpu_we   = 1'b1;
        model_push(cpu_addr, cpu_data);
      end else begin
        cpu_we = 1'b0;
      end
      step();
    end
    cpu_we     = 1'b0;
    vram_ready = 1'b1;
    wait_idle("toggle");
    chk("toggle_count", 64'(accepted - acc0), 64'(4 * Beats));

`ifdef SCREEN_BRIDGE_EXPAND_EN
    // One word expands into 16 pixels at offset*16.
    acc0 = accepted;
    cpu_write(15'h4001, 16'h0001, 1'b1, 1'b1);
    step();
    chk("exp_pix0", {vram_we, vram_addr, vram_data}, {1'b1, 17'd16, Fg});
    step();
    chk("exp_pix1", {vram_we, vram_addr, vram_data}, {1'b1, 17'd17, Bg});
    wait_idle("expand");
    chk("expand_count", 64'(accepted - acc0), 64'd16);
`endif

    // Asynchronous reset while a write is stalled on the port.
    vram_ready = 1'b0;
    cpu_write(15'h4500, 16'h7777, 1'b1, 1'b1);
    cpu_write(15'h4501, 16'h8888, 1'b1, 1'b1);
    chk("arst_pre_we", 64'(vram_we), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_we", 64'(vram_we), 64'd0);
    chk("arst_addr_data", {vram_addr, vram_data}, 64'd0);
    chk("arst_level_busy", {fifo_level, busy}, 64'd0);
    sb_q.delete();
    step();
    reset_n    = 1'b1;
    vram_ready = 1'b1;
    step();
    step();
    chk("arst_after_we", 64'(vram_we), 64'd0);
    chk("arst_after_level", 64'(fifo_level), 64'd0);

    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
